// File: rtl/dcache_victim_ctrl_if.sv
// Bus bundle between the miss controller and its three neighbours: the dcache
// miss path, the victim cache and the memory read port.
interface dcache_victim_ctrl_if #(
    parameter int DCACHE_LINE_WIDTH = 128,
    parameter int VICTIM_ADDR_BITS  = 28
);
    // Handshakes: miss_req_i is held by the dcache until the one-cycle miss_ack_o
    // pulse; mem_req_o is held by the controller until the cycle mem_ack_i is seen.
    logic                         miss_req_i;
    logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i;
    logic                         evict_valid_i;
    logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i;
    logic [DCACHE_LINE_WIDTH-1:0] evict_data_i;
    logic                         miss_ack_o;
    logic [DCACHE_LINE_WIDTH-1:0] refill_data_o;
    logic                         refill_from_victim_o;

    logic [VICTIM_ADDR_BITS-1:0]  dcache2victim_addr_o;
    logic [DCACHE_LINE_WIDTH-1:0] dcache2victim_data_o;
    logic                         victim_wr_en_o;
    logic [DCACHE_LINE_WIDTH-1:0] victim2dcache_data_i;
    logic                         victim_hit_i;

    logic                         mem_req_o;
    logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o;
    logic                         mem_ack_i;
    logic [DCACHE_LINE_WIDTH-1:0] mem_data_i;

    modport slave (
        input  miss_req_i, miss_addr_i, evict_valid_i, evict_addr_i, evict_data_i,
        input  victim2dcache_data_i, victim_hit_i, mem_ack_i, mem_data_i,
        output miss_ack_o, refill_data_o, refill_from_victim_o,
        output dcache2victim_addr_o, dcache2victim_data_o, victim_wr_en_o,
        output mem_req_o, mem_addr_o
    );

    modport master (
        output miss_req_i, miss_addr_i, evict_valid_i, evict_addr_i, evict_data_i,
        output victim2dcache_data_i, victim_hit_i, mem_ack_i, mem_data_i,
        input  miss_ack_o, refill_data_o, refill_from_victim_o,
        input  dcache2victim_addr_o, dcache2victim_data_o, victim_wr_en_o,
        input  mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/dcache_victim_ctrl.sv
// Dcache miss controller: probes the victim cache first, falls back to memory,
// and always writes the evicted line into the victim cache before acknowledging.
module dcache_victim_ctrl #(
    parameter int DCACHE_LINE_WIDTH = 128,
    parameter int VICTIM_ADDR_BITS  = 28,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    dcache_victim_ctrl_if.slave   bus,
    output logic                  busy_o,
    output logic [STAT_WIDTH-1:0] victim_hit_cnt_o,
    output logic [STAT_WIDTH-1:0] victim_miss_cnt_o,
    output logic [2:0]            dbg_state_o
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MEM_REQ   = 3'd2,
        ST_WR_VICTIM = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    state_e                       state_q, state_d;
    logic [VICTIM_ADDR_BITS-1:0]  miss_addr_q, miss_addr_d;
    logic                         evict_valid_q, evict_valid_d;
    logic [VICTIM_ADDR_BITS-1:0]  evict_addr_q, evict_addr_d;
    logic [DCACHE_LINE_WIDTH-1:0] evict_data_q, evict_data_d;
    logic [DCACHE_LINE_WIDTH-1:0] refill_q, refill_d;
    logic                         from_victim_q, from_victim_d;
    logic                         busy_q, busy_d;
    logic [STAT_WIDTH-1:0]        hit_cnt_q, hit_cnt_d;
    logic [STAT_WIDTH-1:0]        miss_cnt_q, miss_cnt_d;

    always_comb begin
        state_d                  = state_q;
        miss_addr_d              = miss_addr_q;
        evict_valid_d            = evict_valid_q;
        evict_addr_d             = evict_addr_q;
        evict_data_d             = evict_data_q;
        refill_d                 = refill_q;
        from_victim_d            = from_victim_q;
        hit_cnt_d                = hit_cnt_q;
        miss_cnt_d               = miss_cnt_q;
        bus.miss_ack_o           = 1'b0;
        bus.dcache2victim_addr_o = '0;
        bus.dcache2victim_data_o = '0;
        bus.victim_wr_en_o       = 1'b0;
        bus.mem_req_o            = 1'b0;
        bus.mem_addr_o           = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.miss_req_i && !flush_i) begin
                    miss_addr_d   = bus.miss_addr_i;
                    evict_valid_d = bus.evict_valid_i;
                    evict_addr_d  = bus.evict_addr_i;
                    evict_data_d  = bus.evict_data_i;
                    state_d       = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                bus.dcache2victim_addr_o = miss_addr_q;
                if (bus.victim_hit_i) begin
                    refill_d      = bus.victim2dcache_data_i;
                    from_victim_d = 1'b1;
                    hit_cnt_d     = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + STAT_ONE;
                    state_d       = evict_valid_q ? ST_WR_VICTIM : ST_RESP;
                end else begin
                    miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + STAT_ONE;
                    state_d    = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = miss_addr_q;
                if (bus.mem_ack_i) begin
                    refill_d      = bus.mem_data_i;
                    from_victim_d = 1'b0;
                    state_d       = evict_valid_q ? ST_WR_VICTIM : ST_RESP;
                end
            end
            ST_WR_VICTIM: begin
                // Runs after the lookup so victim replacement cannot clobber the hit line.
                bus.victim_wr_en_o       = 1'b1;
                bus.dcache2victim_addr_o = evict_addr_q;
                bus.dcache2victim_data_o = evict_data_q;
                state_d                  = ST_RESP;
            end
            ST_RESP: begin
                bus.miss_ack_o = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            miss_addr_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            refill_q      <= '0;
            from_victim_q <= 1'b0;
            busy_q        <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            miss_addr_q   <= miss_addr_d;
            evict_valid_q <= evict_valid_d;
            evict_addr_q  <= evict_addr_d;
            evict_data_q  <= evict_data_d;
            refill_q      <= refill_d;
            from_victim_q <= from_victim_d;
            busy_q        <= busy_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign bus.refill_data_o        = refill_q;
    assign bus.refill_from_victim_o = from_victim_q;
    assign busy_o                   = busy_q;
    assign victim_hit_cnt_o         = hit_cnt_q;
    assign victim_miss_cnt_o        = miss_cnt_q;
    assign dbg_state_o              = state_q;
endmodule

// File: doc/dcache_victim_ctrl.md
# dcache_victim_ctrl

Miss-handling controller that sits directly upstream of `victim_cache`. It sits between the data cache miss path, the victim cache and the memory interface. On a dcache miss it probes the victim cache and, on a victim hit, returns that line without a memory access; otherwise it fetches the line from memory. In both cases it writes the line evicted from the dcache into the victim cache before acknowledging the refill.

## Interface
- `DCACHE_LINE_WIDTH`, 128, line width in bits.
- `VICTIM_ADDR_BITS`, 28, line address width (tag + index).
- `STAT_WIDTH`, 32, width of each statistics counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  cache flush; see Operation.
- `miss_req_i`  in  1  dcache miss request; held high until `miss_ack_o`.
- `miss_addr_i`  in  VICTIM_ADDR_BITS  missing line address.
- `evict_valid_i`  in  1  the dcache line being replaced is valid.
- `evict_addr_i`  in  VICTIM_ADDR_BITS  address of the replaced line.
- `evict_data_i`  in  DCACHE_LINE_WIDTH  data of the replaced line.
- `miss_ack_o`  out  1  one-cycle pulse; refill data valid.
- `refill_data_o`  out  DCACHE_LINE_WIDTH  refill line.
- `refill_from_victim_o`  out  1  refill was served by the victim cache; valid with `miss_ack_o`.
- `busy_o`  out  1  FSM not in IDLE.
- `dcache2victim_addr_o`  out  VICTIM_ADDR_BITS  victim lookup or write address.
- `dcache2victim_data_o`  out  DCACHE_LINE_WIDTH  victim write data.
- `victim_wr_en_o`  out  1  victim write strobe.
- `victim2dcache_data_i`  in  DCACHE_LINE_WIDTH  victim lookup data (combinational).
- `victim_hit_i`  in  1  victim lookup hit (combinational).
- `mem_req_o`  out  1  memory line read request.
- `mem_addr_o`  out  VICTIM_ADDR_BITS  memory read address.
- `mem_ack_i`  in  1  memory read done; `mem_data_i` valid.
- `mem_data_i`  in  DCACHE_LINE_WIDTH  memory line data.
- `victim_hit_cnt_o`  out  STAT_WIDTH  count of victim-served misses.
- `victim_miss_cnt_o`  out  STAT_WIDTH  count of memory-served misses.

## Operation
- States: IDLE, LOOKUP, MEM_REQ, WR_VICTIM, RESP.
- **IDLE**
  - If `miss_req_i=1` and `flush_i=0`, register `miss_addr_i`, `evict_valid_i`, `evict_addr_i` and `evict_data_i`, then go to LOOKUP.
  - Input changes after this capture are ignored until the next IDLE.
- **LOOKUP**
  - Drive `dcache2victim_addr_o` = captured miss address, with `victim_wr_en_o=0`.
  - On `victim_hit_i=1`: register `victim2dcache_data_i` into the refill register, set the from-victim flag, and increment `victim_hit_cnt_o`.
  - Then go to WR_VICTIM if captured `evict_valid=1`, else to RESP.
  - On `victim_hit_i=0`: increment `victim_miss_cnt_o` and go to MEM_REQ.
- **MEM_REQ**
  - Hold `mem_req_o=1` with `mem_addr_o` = miss address.
  - On `mem_ack_i=1`: register `mem_data_i`, clear the from-victim flag, and go to WR_VICTIM or RESP (same rule as LOOKUP).
  - `mem_ack_i` is ignored in all other states.
- **WR_VICTIM**
  - Exactly one cycle of `victim_wr_en_o=1`, with `dcache2victim_addr_o`/`dcache2victim_data_o` = captured evict address/data.
  - Then go to RESP.
- **RESP**
  - `miss_ack_o=1` for one cycle; `refill_data_o` and `refill_from_victim_o` are valid.
  - Then go to IDLE. The dcache drops `miss_req_i` in the cycle after the ack.
- The lookup always precedes the eviction write, so a round-robin replacement in the victim cache cannot destroy the hit line before it is read.
- A line hit in the victim cache is not invalidated there. A later eviction of the same address updates that entry in place.
- Counters saturate at all-ones; they are cleared only by `rst`.
- **flush_i**
  - Honoured only in IDLE, where it blocks acceptance of a request that cycle.
  - The system guarantees no flush while `busy_o=1`; `flush_i` in other states has no effect on this block.
- `refill_data_o` holds its last value outside RESP.

## Timing
- All outputs, counters and registers are 0 on `rst`; state is IDLE.
- `rst` asserted mid-operation aborts immediately: `mem_req_o` drops asynchronously and no ack is issued.
- With the request first seen high in cycle 0:
  - Victim hit, evict valid: LOOKUP in cycle 1, WR_VICTIM in cycle 2, `miss_ack_o` in cycle 3.
  - Victim hit, no evict: `miss_ack_o` in cycle 2.
  - Victim miss: `mem_req_o` high from cycle 2 through the cycle `mem_ack_i` is seen, inclusive. `mem_ack_i` in cycle 2 (zero-wait) is legal.
  - After `mem_ack_i` in cycle k: ack in cycle k+2 with eviction, k+1 without.
- Earliest next accept is the cycle after `miss_ack_o`.
- `busy_o` = (state != IDLE), registered.
- Victim outputs are sampled only at the end of LOOKUP.

## Test plan
- Reset, then miss 0x0000123 with no evict; victim empty; memory acks after 3 cycles with line A -> `victim_miss_cnt_o=1`, `miss_ack_o` with `refill_data_o`=A and `refill_from_victim_o=0`, and no `victim_wr_en_o`.
- Miss 0x0000456 evicting 0x0000123/A, memory returns B -> one `victim_wr_en_o` pulse with 0x0000123/A, one cycle before the ack with refill B.
- Miss 0x0000123 evicting 0x0000456/B -> `victim_hit_i` taken in cycle 1; ack in cycle 3 with A and `refill_from_victim_o=1`; `mem_req_o` never asserted; `victim_hit_cnt_o=1`.
- Zero-wait memory: `mem_ack_i` high in the first MEM_REQ cycle -> `mem_req_o` high exactly one cycle, and the data is captured correctly.
- Assert `rst` during MEM_REQ -> all outputs 0 immediately; the next request is served normally; a `flush_i` pulse coincident with `miss_req_i` in IDLE delays acceptance by one cycle.
- Preload `victim_hit_cnt_o` near saturation (force to 0xFFFFFFFE, then two hits) -> the counter stays at 0xFFFFFFFF.
